// File: rtl/dispatch_buffer.sv
// In-order dispatch buffer: a circular FIFO of decoded instructions that issues the
// oldest entry to one execution unit, holding privileged ops until the back end is idle.
package cvw;
    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;
    localparam cvw_t CVW_DEFAULT = '{XLEN: 32};
endpackage

module dispatch_buffer #(
    parameter cvw::cvw_t P     = cvw::CVW_DEFAULT,
    parameter int        DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         FlushD,
    input  logic                         InstrValidD,
    input  logic [31:0]                  InstrD,
    input  logic [P.XLEN-1:0]            PCD,
    input  logic                         IEUOp,
    input  logic                         MDUOp,
    input  logic                         CryptoOp,
    input  logic                         FPUOp,
    input  logic                         MemOp,
    input  logic                         PrivOp,
    output logic                         DispatchReadyD,
    output logic [31:0]                  IssueInstr,
    output logic [P.XLEN-1:0]            IssuePC,
    output logic [5:0]                   IssueValid,
    input  logic [5:0]                   UnitReady,
    input  logic                         PipeIdle,
    output logic [$clog2(DEPTH+1)-1:0]   BufCount
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int XLEN = P.XLEN;

    logic [31:0]     instrMem_q [DEPTH];
    logic [XLEN-1:0] pcMem_q    [DEPTH];
    logic [5:0]      typeMem_q  [DEPTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic       full, empty, enq, deq, gate;
    logic [5:0] rawType, inType, headType;

    assign rawType = {IEUOp, MDUOp, CryptoOp, FPUOp, MemOp, PrivOp};

    // Stored class is always one-hot: highest flag wins, no flag means IEU.
    always_comb begin
        inType = 6'b100000;
        casez (rawType)
            6'b1?????: inType = 6'b100000;
            6'b01????: inType = 6'b010000;
            6'b001???: inType = 6'b001000;
            6'b0001??: inType = 6'b000100;
            6'b00001?: inType = 6'b000010;
            6'b000001: inType = 6'b000001;
            default:   inType = 6'b100000;
        endcase
    end

    assign full           = (count_q == CW'(DEPTH));
    assign empty          = (count_q == '0);
    assign DispatchReadyD = ~full & ~reset;
    assign enq            = InstrValidD & DispatchReadyD;

    assign headType   = typeMem_q[rdPtr_q];
    assign gate       = ~headType[0] | PipeIdle;
    assign IssueValid = headType & {6{~empty & gate}};
    assign deq        = |(IssueValid & UnitReady);

    assign IssueInstr = instrMem_q[rdPtr_q];
    assign IssuePC    = pcMem_q[rdPtr_q];
    assign BufCount   = count_q;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (reset | FlushD) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (enq) wrPtr_d = wrPtr_q + 1'b1;
            if (deq) rdPtr_d = rdPtr_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wrPtr_q <= wrPtr_d;
        rdPtr_q <= rdPtr_d;
        count_q <= count_d;
    end

    // Storage is cleared on reset only so the head outputs are never unknown.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instrMem_q[i] <= '0;
                pcMem_q[i]    <= '0;
                typeMem_q[i]  <= '0;
            end
        end else if (enq & ~FlushD) begin
            instrMem_q[wrPtr_q] <= InstrD;
            pcMem_q[wrPtr_q]    <= PCD;
            typeMem_q[wrPtr_q]  <= inType;
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Scoreboard bench for dispatch_buffer: a queue of expected entries is filled on
// accepted enqueues and checked against the issue port every cycle.
module tb_dispatch_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  kind;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        FlushD = 1'b0;
    logic        InstrValidD = 1'b0;
    logic [31:0] InstrD = '0;
    logic [31:0] PCD = '0;
    logic [5:0]  flags = '0;
    logic        DispatchReadyD;
    logic [31:0] IssueInstr;
    logic [31:0] IssuePC;
    logic [5:0]  IssueValid;
    logic [5:0]  UnitReady = '0;
    logic        PipeIdle = 1'b1;
    logic [2:0]  BufCount;

    entry_t      expQ[$];
    int          checks = 0;
    int          failures = 0;
    bit          checking = 0;
    bit          expectDeq = 0;
    logic [5:0]  expIV;

    dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .FlushD(FlushD), .InstrValidD(InstrValidD),
        .InstrD(InstrD), .PCD(PCD),
        .IEUOp(flags[5]), .MDUOp(flags[4]), .CryptoOp(flags[3]),
        .FPUOp(flags[2]), .MemOp(flags[1]), .PrivOp(flags[0]),
        .DispatchReadyD(DispatchReadyD), .IssueInstr(IssueInstr), .IssuePC(IssuePC),
        .IssueValid(IssueValid), .UnitReady(UnitReady), .PipeIdle(PipeIdle),
        .BufCount(BufCount)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] classOf(input logic [5:0] f);
        for (int i = 5; i >= 0; i--)
            if (f[i]) return 6'(1) << i;
        return 6'b100000;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of one clock edge: flush/reset empties, otherwise pop on handshake and push on accept.
    always @(posedge clk) begin : model
        automatic int sz = expQ.size();
        automatic entry_t e;
        if (reset) checking <= 1'b1;
        if (reset || FlushD) begin
            expQ.delete();
        end else begin
            if (expectDeq) void'(expQ.pop_front());
            if (InstrValidD && sz < DEPTH) begin
                e.instr = InstrD;
                e.pc    = PCD;
                e.kind  = classOf(flags);
                expQ.push_back(e);
            end
        end
    end

    // Monitor: compares the issue port against the model head mid-cycle.
    always @(negedge clk) begin
        if (checking) begin
            expIV = '0;
            if (expQ.size() > 0 && (!expQ[0].kind[0] || PipeIdle)) expIV = expQ[0].kind;
            checkOutput("BufCount", 64'(BufCount), 64'(expQ.size()));
            checkOutput("DispatchReadyD", 64'(DispatchReadyD), 64'(!reset && expQ.size() < DEPTH));
            checkOutput("IssueValid", 64'(IssueValid), 64'(expIV));
            if (expIV != '0) begin
                checkOutput("IssueInstr", 64'(IssueInstr), 64'(expQ[0].instr));
                checkOutput("IssuePC", 64'(IssuePC), 64'(expQ[0].pc));
            end
            expectDeq = (expIV & UnitReady) != '0;
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [5:0] f, input logic [5:0] rdy, input logic idle,
                                 input logic fl = 1'b0, input logic rst = 1'b0);
        @(posedge clk);
        #1;
        InstrValidD = v;
        InstrD      = instr;
        PCD         = pc;
        flags       = f;
        UnitReady   = rdy;
        PipeIdle    = idle;
        FlushD      = fl;
        reset       = rst;
    endtask

    task automatic idleCycles(input int n, input logic [5:0] rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, rdy, 1'b1);
    endtask

    function automatic logic [5:0] randFlags();
        case ($urandom_range(0, 3))
            0:       return '0;
            3:       return 6'($urandom);
            default: return 6'(1) << $urandom_range(0, 5);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b1);

        // Single IEU add with every unit ready.
        applyStimulus(1'b1, 32'h00B50533, 32'h80000000, 6'b100000, 6'h3f, 1'b1);
        idleCycles(3, 6'h3f);

        // Fill to DEPTH with units stalled, try a fifth, then drain across the wrap.
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 32'h1000 + i, 32'h80000100 + 4 * i, 6'b100000, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
        idleCycles(6, 6'h3f);

        // Alternating MDU/FPU stream with only MDU ready.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 32'h2000 + i, 32'h80000200 + 4 * i,
                          (i % 2 == 0) ? 6'b010000 : 6'b000100, 6'b010000, 1'b1);
        idleCycles(3, 6'b010000);
        idleCycles(8, 6'b010100);

        // ecall held while the pipe is busy, younger IEU op behind it.
        applyStimulus(1'b1, 32'h00000073, 32'h80000300, 6'b000001, 6'h3f, 1'b0);
        applyStimulus(1'b1, 32'h00B50533, 32'h80000304, 6'b100000, 6'h3f, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, '0, 6'h3f, 1'b0);
        idleCycles(4, 6'h3f);

        // Three buffered, then flush colliding with an enqueue and a dequeue.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'h3000 + i, 32'h80000400 + 4 * i, 6'b000010, '0, 1'b1);
        applyStimulus(1'b1, 32'h3fff, 32'h80000500, 6'b100000, 6'h3f, 1'b1, 1'b1);
        idleCycles(3, 6'h3f);

        // No class flags: defaults to IEU, steady one-per-cycle streaming.
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 32'h0000000B, 32'h80000600 + 4 * i, 6'b000000, 6'h3f, 1'b1);
        idleCycles(3, 6'h3f);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, $urandom, randFlags(),
                          6'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 199) == 0));

        idleCycles(DEPTH + 4, 6'h3f);
        @(negedge clk);
        checkOutput("drained BufCount", 64'(BufCount), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispatch_buffer.md
Name: dispatch_buffer

Overview:
- In-order instruction buffer placed directly downstream of the dispatch type decoder.
- Captures each decoded instruction with its PC and six unit-class flags into a circular FIFO.
- Presents the oldest entry to the one execution unit selected by its class, using a valid/ready handshake per unit.
- Serializes privileged instructions: they issue only once the back end reports idle.

Parameters:
P, (none), cvw_t configuration struct; only P.XLEN is used here, for PC width.
DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
FlushD  input  1  synchronous flush; discards all buffered entries
InstrValidD  input  1  upstream holds a valid decoded instruction
InstrD  input  32  instruction bits
PCD  input  P.XLEN  instruction PC
IEUOp, MDUOp, CryptoOp, FPUOp, MemOp, PrivOp  input  1 each  class flags from the type decoder
DispatchReadyD  output  1  buffer can accept an instruction this cycle
IssueInstr  output  32  head instruction
IssuePC  output  P.XLEN  head PC
IssueValid  output  6  one-hot issue request; bit order {IEU,MDU,Crypto,FPU,Mem,Priv} = [5:0]
UnitReady  input  6  per-unit ready; same bit order as IssueValid
PipeIdle  input  1  all previously issued instructions have completed
BufCount  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Entry storage: {Instr[31:0], PC[XLEN-1:0], Type[5:0]}.
  - Type = {IEUOp,MDUOp,CryptoOp,FPUOp,MemOp,PrivOp}.
  - If all six flags are 0, Type is stored as IEU (6'b100000).
  - If more than one flag is set, the highest-numbered set bit is kept and the others are cleared. Every stored Type is therefore one-hot.
- State: write pointer, read pointer (each log2(DEPTH) bits, wrapping modulo DEPTH) and Count (0..DEPTH). Full = (Count==DEPTH); Empty = (Count==0).
- DispatchReadyD = ~Full & ~reset.
  - It depends on registered state only, never on UnitReady.
  - There is no same-cycle pass-through when full.
- Enq = InstrValidD & DispatchReadyD. On an Enq edge the entry is written at the write pointer, and the write pointer and Count advance.
- Head request: HeadValid = ~Empty. Gate = ~(HeadType[0]) | PipeIdle.
- IssueValid = HeadType & {6{HeadValid & Gate}}.
  - IssueValid never depends on UnitReady.
  - Once asserted, IssueValid and the issue data hold stable until the entry is accepted or a flush/reset occurs.
- Deq = |(IssueValid & UnitReady). On a Deq edge the read pointer advances and Count decrements.
- Simultaneous Enq and Deq: Count is unchanged and both pointers advance. This is legal at any occupancy except Full, where Enq is already blocked.
- Latency:
  - An instruction enqueued at edge N is presented on IssueValid no earlier than cycle N+1. There is no bypass.
  - Maximum sustained throughput is 1 instruction per cycle.
- IssueInstr and IssuePC always reflect the head slot. Their values are don't-care when IssueValid==0, but must be X-free after reset.
- Privileged serialization:
  - A Priv head waits with IssueValid=0 while PipeIdle=0.
  - Younger entries never bypass the head, so issue is strictly in order.
- FlushD:
  - On the edge it sets Count=0 and resets both pointers to 0.
  - It overrides a same-cycle Enq and a same-cycle Deq. The Deq handshake still counts as accepted by the unit, but the buffer is emptied regardless.
- reset: same effect as FlushD.
  - Reset values: IssueValid=0, BufCount=0, DispatchReadyD=0 while reset is high and 1 on the first cycle after it.
  - Storage contents need not be cleared.
- reset asserted mid-operation discards all entries. Nothing issues on the cycle after reset deasserts.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

Test Plan:
1. Reset, then enqueue one IEU add (InstrD=0x00B50533, PCD=0x80000000) with UnitReady=6'b111111 -> IssueValid=6'b100000 on the next cycle with IssuePC=0x80000000; BufCount goes 1 then 0.
2. Fill with DEPTH=4 instructions while UnitReady=0 -> DispatchReadyD=0 at BufCount=4 and a fifth InstrValidD is not accepted; then raise UnitReady -> issues drain in order, one per cycle, including across the pointer wrap.
3. Stream of alternating MDU and FPU ops with UnitReady=6'b010000 -> only the MDU head issues; the FPU head stalls with IssueValid=6'b000100 stable until UnitReady[2] rises.
4. ecall (0x00000073, PrivOp) at head with PipeIdle=0 for 3 cycles -> IssueValid=0 for those 3 cycles; when PipeIdle=1, IssueValid=6'b000001, and a younger IEU op behind it waits.
5. Buffer holding 3 entries, FlushD asserted in the same cycle as InstrValidD and UnitReady=all-ones -> BufCount=0 and IssueValid=0 next cycle; the new instruction is not stored.
6. All flags 0 on input (InstrD=0x0000000B) -> issued with IssueValid=6'b100000; steady enqueue/dequeue of 1 per cycle keeps BufCount constant at 1.
